// File: rtl/faccel_pkg.sv
// Shared definitions for the factorial accelerator host interface:
// accelerator register map, status bit positions and the sequencer state set.
package faccel_pkg;

    localparam logic [1:0] FA_ADDR_N  = 2'd0;
    localparam logic [1:0] FA_ADDR_GO = 2'd1;
    localparam logic [1:0] FA_ADDR_ST = 2'd2;
    localparam logic [1:0] FA_ADDR_F  = 2'd3;

    localparam int unsigned ST_DONE = 0;
    localparam int unsigned ST_ERR  = 1;

    localparam logic [3:0] GO_BIT = 4'b0001;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_N,
        S_WR_GO,
        S_GO_CLR,
        S_ST_ADDR,
        S_ST_SAMP,
        S_F_ADDR,
        S_F_SAMP,
        S_RESP
    } state_e;

    typedef struct packed {
        logic       we;
        logic [1:0] a;
        logic [3:0] d;
    } fa_wr_t;

    // Accelerator write-port value for a given sequencer state.
    function automatic fa_wr_t fa_decode(input state_e s, input logic [3:0] n);
        fa_wr_t w;
        w = '0;
        case (s)
            S_WR_N:    begin w.we = 1'b1; w.a = FA_ADDR_N;  w.d = n;      end
            S_WR_GO:   begin w.we = 1'b1; w.a = FA_ADDR_GO; w.d = GO_BIT; end
            S_GO_CLR:  begin w.we = 1'b1; w.a = FA_ADDR_GO; w.d = '0;     end
            S_ST_ADDR: w.a = FA_ADDR_ST;
            S_ST_SAMP: w.a = FA_ADDR_ST;
            S_F_ADDR:  w.a = FA_ADDR_F;
            S_F_SAMP:  w.a = FA_ADDR_F;
            default:   w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/faccel_host_if.sv
// Host-side command sequencer for the factorial accelerator. One request
// (n) becomes: write N, pulse Go, poll Status until done/err, read F, and
// the result is returned on a valid/ready response channel.
// Optional: define FACCEL_HOST_TIMEOUT_EN to bound polling at POLL_MAX
// status samples (timeout reported as rsp_err with rsp_data = 0).
module faccel_host_if
    import faccel_pkg::*;
#(
    parameter int unsigned DW       = 32,
    parameter int unsigned POLL_MAX = 255,
    parameter int unsigned CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_n,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic          fa_we,
    output logic [1:0]    fa_a,
    output logic [3:0]    fa_d,
    input  logic [DW-1:0] fa_out
);

    if (CW < $clog2(POLL_MAX + 1)) begin : g_cw_check
        $error("faccel_host_if: CW too narrow for POLL_MAX");
    end

    state_e        state_q, state_d;
    logic [3:0]    n_q, n_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    fa_wr_t        fa_wr_q, fa_wr_d;

`ifdef FACCEL_HOST_TIMEOUT_EN
    localparam logic [CW-1:0] POLL_LIM = CW'(POLL_MAX);
    logic [CW-1:0] poll_q, poll_d, poll_inc;
`endif

    // Next-state, request latch, response capture and poll counting.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef FACCEL_HOST_TIMEOUT_EN
        poll_d     = poll_q;
        poll_inc   = (poll_q == '1) ? poll_q : poll_q + 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    n_d     = req_n;
                    state_d = S_WR_N;
`ifdef FACCEL_HOST_TIMEOUT_EN
                    poll_d  = '0;
`endif
                end
            end
            S_WR_N:    state_d = S_WR_GO;
            S_WR_GO:   state_d = S_GO_CLR;
            S_GO_CLR:  state_d = S_ST_ADDR;
            S_ST_ADDR: state_d = S_ST_SAMP;
            S_ST_SAMP: begin
                if (fa_out[ST_ERR]) begin
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                    state_d    = S_RESP;
                end else if (fa_out[ST_DONE]) begin
                    state_d = S_F_ADDR;
                end else begin
`ifdef FACCEL_HOST_TIMEOUT_EN
                    // The sample just taken counts toward the limit, so the
                    // timeout fires on the POLL_MAX-th not-done sample.
                    poll_d = poll_inc;
                    if (poll_inc >= POLL_LIM) begin
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_ST_ADDR;
                    end
`else
                    state_d = S_ST_ADDR;
`endif
                end
            end
            S_F_ADDR:  state_d = S_F_SAMP;
            S_F_SAMP: begin
                rsp_data_d = fa_out;
                rsp_err_d  = 1'b0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
        // Registering the decode of the next state keeps the write port a
        // clean flop output that lines up with the current state.
        fa_wr_d = fa_decode(state_d, n_d);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            fa_wr_q    <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            fa_wr_q    <= fa_wr_d;
        end
    end

`ifdef FACCEL_HOST_TIMEOUT_EN
    // Saturating status-poll counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) poll_q <= '0;
        else      poll_q <= poll_d;
    end
`endif

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign fa_we     = fa_wr_q.we;
    assign fa_a      = fa_wr_q.a;
    assign fa_d      = fa_wr_q.d;

endmodule

// File: tb/tb_faccel_host_if.sv
// Self-checking bench for faccel_host_if with a behavioural accelerator
// model (registered read port, busy for n cycles after Go, err for n >= 13).
module tb_faccel_host_if;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_n = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        fa_we;
    logic [1:0]  fa_a;
    logic [3:0]  fa_d;
    logic [31:0] fa_out;

    always #5 clk = ~clk;

    faccel_host_if #(.DW(32), .POLL_MAX(4), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fa_we(fa_we), .fa_a(fa_a), .fa_d(fa_d), .fa_out(fa_out)
    );

    // ---------------- accelerator model ----------------
    logic [3:0]  m_n, m_cnt;
    logic        m_busy, m_done, m_err;
    logic [31:0] m_f;
    logic        stub_never_done = 1'b0;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_n <= '0; m_cnt <= '0; m_busy <= 1'b0; m_done <= 1'b0;
            m_err <= 1'b0; m_f <= '0; fa_out <= '0;
        end else begin
            if (fa_we && fa_a == 2'd0) m_n <= fa_d;
            if (fa_we && fa_a == 2'd1 && fa_d[0] && !m_busy) begin
                m_busy <= 1'b1; m_cnt <= m_n; m_done <= 1'b0; m_err <= 1'b0;
                m_f <= fact(m_n);
            end else if (m_busy) begin
                if (m_cnt == 4'd0) begin
                    m_busy <= 1'b0;
                    if (!stub_never_done) begin
                        if (m_n >= 4'd13) m_err <= 1'b1;
                        else              m_done <= 1'b1;
                    end
                end else begin
                    m_cnt <= m_cnt - 4'd1;
                end
            end
            case (fa_a)
                2'd0:    fa_out <= {28'd0, m_n};
                2'd2:    fa_out <= {30'd0, m_err, m_done};
                2'd3:    fa_out <= m_f;
                default: fa_out <= '0;
            endcase
        end
    end

    // ---------------- checking ----------------
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned lat;
        bit          to;
        bit          saw_rdy;
        bit          saw_a3;
        bit          stable;
        bit          dropped;
    } res_t;

    // One request/response; lat counts clock edges from the accept edge to
    // the edge that raises rsp_valid.
    task automatic run_txn(input logic [3:0] n, input int unsigned hold,
                           input int unsigned budget, output res_t r);
        int unsigned w;
        r = '{default: 0};
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        if (!req_ready) begin r.to = 1'b1; return; end
        req_n = n; req_valid = 1'b1; rsp_ready = (hold == 0);
        @(posedge clk); #1; req_valid = 1'b0; r.lat = 1;
        while (!rsp_valid && r.lat < budget) begin
            if (req_ready) r.saw_rdy = 1'b1;
            if (fa_a == 2'd3) r.saw_a3 = 1'b1;
            @(posedge clk); #1; r.lat++;
        end
        if (!rsp_valid) begin r.to = 1'b1; return; end
        r.data = rsp_data; r.err = rsp_err; r.stable = 1'b1;
        for (int i = 0; i < int'(hold); i++) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_data !== r.data || rsp_err !== r.err) r.stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        r.dropped = !rsp_valid;
    endtask

    typedef struct {
        logic [3:0]  n;
        int unsigned hold;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];
    res_t r;
    int unsigned w;

    initial begin
        vecs[0] = '{n: 4'd0,  hold: 0,  exp_data: 32'd1,         exp_err: 1'b0};
        vecs[1] = '{n: 4'd12, hold: 0,  exp_data: 32'd479001600, exp_err: 1'b0};
        vecs[2] = '{n: 4'd13, hold: 0,  exp_data: 32'd0,         exp_err: 1'b1};
        vecs[3] = '{n: 4'd6,  hold: 10, exp_data: 32'd720,       exp_err: 1'b0};
        vecs[4] = '{n: 4'd1,  hold: 0,  exp_data: 32'd1,         exp_err: 1'b0};
        vecs[5] = '{n: 4'd3,  hold: 3,  exp_data: 32'd6,         exp_err: 1'b0};

        // Reset values.
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data",  rsp_data,       32'd0);
        check("rst_rsp_err",   32'(rsp_err),   32'd0);
        check("rst_fa_we",     32'(fa_we),     32'd0);
        check("rst_fa_a",      32'(fa_a),      32'd0);
        check("rst_fa_d",      32'(fa_d),      32'd0);
        @(negedge clk); rst = 1'b1;

        // n=5: write sequence N, Go=1, Go=0 on consecutive cycles.
        @(negedge clk);
        req_n = 4'd5; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        check("seq_wrn", {29'd0, fa_we, fa_a}, {29'd0, 1'b1, 2'd0});
        check("seq_wrn_d", 32'(fa_d), 32'd5);
        @(posedge clk); #1;
        check("seq_go1", {25'd0, fa_we, fa_a, fa_d}, {25'd0, 1'b1, 2'd1, 4'd1});
        @(posedge clk); #1;
        check("seq_go0", {25'd0, fa_we, fa_a, fa_d}, {25'd0, 1'b1, 2'd1, 4'd0});
        @(posedge clk); #1;
        check("seq_st_addr", {29'd0, fa_we, fa_a}, {29'd0, 1'b0, 2'd2});
        w = 0;
        while (!rsp_valid && w < 200) begin @(posedge clk); #1; w++; end
        check("seq5_valid", 32'(rsp_valid), 32'd1);
        check("seq5_data",  rsp_data, 32'd120);
        check("seq5_err",   32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        check("seq5_drop",  32'(rsp_valid), 32'd0);

        // Table-driven transactions (back-to-back).
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].n, vecs[i].hold, 400, r);
            check($sformatf("v%0d_timeout", i), 32'(r.to), 32'd0);
            if (!r.to) begin
                check($sformatf("v%0d_data", i),    r.data, vecs[i].exp_data);
                check($sformatf("v%0d_err", i),     32'(r.err), 32'(vecs[i].exp_err));
                check($sformatf("v%0d_rdy_busy", i), 32'(r.saw_rdy), 32'd0);
                check($sformatf("v%0d_stable", i),  32'(r.stable), 32'd1);
                check($sformatf("v%0d_one_done", i), 32'(r.dropped), 32'd1);
                if (vecs[i].exp_err) check($sformatf("v%0d_no_f_read", i), 32'(r.saw_a3), 32'd0);
                if (vecs[i].n == 4'd0) check("v0_latency", r.lat, 32'd8);
            end
        end

        // Reset in the middle of polling for n=7, then n=4.
        @(negedge clk);
        req_n = 4'd7; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        w = 0;
        while (fa_a != 2'd2 && w < 50) begin @(posedge clk); #1; w++; end
        check("mid_reached_poll", 32'(fa_a), 32'd2);
        #2; rst = 1'b0; #1;
        check("mid_req_ready", 32'(req_ready), 32'd1);
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rsp_data",  rsp_data,       32'd0);
        check("mid_rsp_err",   32'(rsp_err),   32'd0);
        check("mid_fa_we",     32'(fa_we),     32'd0);
        check("mid_fa_a",      32'(fa_a),      32'd0);
        check("mid_fa_d",      32'(fa_d),      32'd0);
        @(negedge clk); rst = 1'b1;
        run_txn(4'd4, 0, 400, r);
        check("post_rst_timeout", 32'(r.to), 32'd0);
        check("post_rst_data", r.data, 32'd24);
        check("post_rst_err",  32'(r.err), 32'd0);

        // Accelerator that never reports done.
        stub_never_done = 1'b1;
        run_txn(4'd3, 0, 100, r);
`ifdef FACCEL_HOST_TIMEOUT_EN
        check("tmo_timeout", 32'(r.to), 32'd0);
        check("tmo_err",     32'(r.err), 32'd1);
        check("tmo_data",    r.data, 32'd0);
        check("tmo_latency", r.lat, 32'd12);
        check("tmo_no_f_read", 32'(r.saw_a3), 32'd0);
`else
        check("stuck_no_valid", 32'(r.to), 32'd1);
        check("stuck_valid_low", 32'(rsp_valid), 32'd0);
        check("stuck_rdy_low", 32'(req_ready), 32'd0);
`endif
        @(negedge clk); rst = 1'b0; stub_never_done = 1'b0;
        @(negedge clk); rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/faccel_host_if.md
Name: faccel_host_if

Overview:
- Upstream command sequencer for the factorial accelerator.
- Accepts a factorial request (n) on a valid/ready handshake and drives the accelerator's write port (we, a, d) through this sequence: load N, pulse Go, poll Status until done, read F.
- Returns the result and an error flag on a valid/ready response handshake.
- Sits between the processor-side I/O logic and the accelerator, so software issues one request instead of a polling loop.

Parameters:
- DW, 32, result width; matches the accelerator's out bus.
- POLL_MAX, 255, maximum status samples before a timeout (used only with the optional feature).
- CW, 8, poll counter width; CW ≥ clog2(POLL_MAX+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_n  in  4  factorial operand.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DW  n! result; 0 when rsp_err is set.
- rsp_err  out  1  accelerator error or timeout.
- fa_we  out  1  accelerator write enable.
- fa_a  out  2  accelerator register select: 0=N, 1=Go, 2=Status, 3=F.
- fa_d  out  4  accelerator write data.
- fa_out  in  DW  accelerator read data for the register selected by fa_a.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_data=0; rsp_err=0.
  - fa_we=0; fa_a=0; fa_d=0; poll counter=0.
- fa_we, fa_a and fa_d are registered outputs; each is a decoded function of the current state only.
- Status register bits: bit0=done, bit1=err. All other bits are ignored.
- States and transitions (one cycle each unless stated):
  - IDLE: req_ready=1. On req_valid&&req_ready, latch req_n and go to WR_N.
  - WR_N: we=1, a=0, d=n_latched → WR_GO.
  - WR_GO: we=1, a=1, d=4'b0001 → GO_CLR.
  - GO_CLR: we=1, a=1, d=0 → ST_ADDR. This makes Go a one-cycle pulse.
  - ST_ADDR: we=0, a=2 → ST_SAMP. This is the settle cycle.
  - ST_SAMP: a=2; sample fa_out.
    - err=1 → RESP with rsp_err=1, rsp_data=0.
    - done=1 → F_ADDR.
    - Otherwise increment the poll counter and go to ST_ADDR.
  - F_ADDR: a=3 → F_SAMP.
  - F_SAMP: register rsp_data=fa_out, rsp_err=0 → RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE and drop rsp_valid the next cycle.
- rsp_data and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- req_ready=0 in every state except IDLE. A request arriving during RESP waits; no overlap or queuing.
- Minimum latency from request accept to rsp_valid is 8 cycles (accept edge → WR_N, WR_GO, GO_CLR, ST_ADDR, ST_SAMP, F_ADDR, F_SAMP → RESP), plus 2 cycles per extra poll.
- n=0 and n=1 are passed through unchanged; the result comes from the accelerator.
- No local range check on n; overflow (n ≥ 13) is reported by the accelerator's err bit.
- Reset asserted mid-sequence returns to IDLE immediately. Any partial accelerator transaction is abandoned; the accelerator is reset by the same rst net.
- The poll counter clears on request accept and saturates at its maximum.

Optional Feature:
- Macro: FACCEL_HOST_TIMEOUT_EN.
- Defined: in ST_SAMP, if the poll counter reaches POLL_MAX with done=0 and err=0, go to RESP with rsp_err=1 and rsp_data=0.
  - The accelerator is not reset; the next request reloads N and Go.
- Undefined: polling is unbounded and the counter logic is removed.

Decomposition:
- Shared package faccel_pkg:
  - register address constants FA_ADDR_N=0, FA_ADDR_GO=1, FA_ADDR_ST=2, FA_ADDR_F=3;
  - status bit indices ST_DONE=0, ST_ERR=1;
  - GO_BIT=4'b0001;
  - state encoding for this block.
- No sub-module is needed: one FSM plus output registers. The poll counter stays inline.

Test Plan:
- Instantiate with the real faccel. req_n=5, rsp_ready=1.
  - Expect fa writes N=5, Go=1, Go=0 in consecutive cycles.
  - Expect rsp_data=120, rsp_err=0.
- Back-to-back requests n=0 then n=12.
  - Expect responses 1 and 479001600 in order.
  - Expect req_ready=0 between accept and response.
- req_n=13.
  - Expect rsp_err=1, rsp_data=0.
  - Expect no F read (fa_a never 3 during this transaction).
- req_n=6 with rsp_ready held low for 10 cycles.
  - Expect rsp_valid held and rsp_data=720 stable throughout.
  - Expect exactly one completion when rsp_ready rises.
- Assert rst low while in the polling states during n=7.
  - Expect all outputs at reset values asynchronously.
  - After release, a new n=4 request returns 24.
- With FACCEL_HOST_TIMEOUT_EN and POLL_MAX=4, use a stub accelerator whose status never sets done.
  - Expect rsp_err=1 after 4 samples; with the macro undefined, rsp_valid stays 0 for 100 cycles.
